// File: rtl/bp_perceptron_train_ctrl_if.sv
// Training request, fetch lookup and weight-RAM port signals of the perceptron training controller.
// master = the controller, slave = EX / fetch / RAM side.
interface bp_perceptron_train_ctrl_if #(
    parameter int HIST_LEN = 14,
    parameter int WEIGHT_W = 8,
    parameter int INDEX_W  = 12
);
    localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
    localparam int SUM_W = WEIGHT_W + 5;

    logic                    train_valid;
    logic                    train_ready;
    logic [INDEX_W-1:0]      train_index;
    logic [HIST_LEN-1:0]     train_ghr;
    logic signed [SUM_W-1:0] train_sum;
    logic                    train_taken;
    logic                    lookup_req;
    logic [INDEX_W-1:0]      lookup_addr;
    logic                    lookup_grant;
    logic                    lookup_stall;
    logic                    ram_en;
    logic                    ram_we;
    logic [INDEX_W-1:0]      ram_addr;
    logic [ROW_W-1:0]        ram_wdata;
    logic [ROW_W-1:0]        ram_rdata;
    logic                    busy;

    modport master (
        input  train_valid, train_index, train_ghr, train_sum, train_taken,
        input  lookup_req, lookup_addr, ram_rdata,
        output train_ready, lookup_grant, lookup_stall,
        output ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport slave (
        output train_valid, train_index, train_ghr, train_sum, train_taken,
        output lookup_req, lookup_addr, ram_rdata,
        input  train_ready, lookup_grant, lookup_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/bp_perceptron_train_ctrl.sv
// Perceptron predictor training sequencer and weight-RAM port arbiter (fetch has priority).
// Optional starvation guard: define BP_TRAIN_STARVE_GUARD_EN to let training seize the port after STARVE_MAX losses.
module bp_perceptron_train_ctrl #(
    parameter int HIST_LEN   = 14,
    parameter int WEIGHT_W   = 8,
    parameter int INDEX_W    = 12,
    parameter int THETA      = 41
`ifdef BP_TRAIN_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 8
`endif
) (
    input logic                        clk,
    input logic                        rst,
    bp_perceptron_train_ctrl_if.master bus
);
    localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
    localparam int SUM_W = WEIGHT_W + 5;
    localparam int K_W   = $clog2(HIST_LEN + 1);
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DECIDE, READ, CAPTURE, UPDATE, WRITE} state_t;

    state_t                  state;
    logic [INDEX_W-1:0]      index_q;
    logic [HIST_LEN-1:0]     ghr_q;
    logic signed [SUM_W-1:0] sum_q;
    logic                    taken_q;
    logic [ROW_W-1:0]        row_q;
    logic [K_W-1:0]          k_q;

    logic                       need_port;
    logic                       guard_fire;
    logic                       ctrl_owns;
    logic                       lookup_win;
    logic                       mispredict;
    logic                       low_conf;
    logic [SUM_W-1:0]           sum_abs;
    logic [HIST_LEN:0]          hist_ext;
    logic                       up;
    logic signed [WEIGHT_W-1:0] w_cur;
    logic signed [WEIGHT_W-1:0] w_next;

`ifdef BP_TRAIN_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q;

    assign guard_fire = (starve_q >= STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (ctrl_owns) begin
            starve_q <= '0;
        end else if (need_port && bus.lookup_req) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end
`else
    assign guard_fire = 1'b0;
`endif

    // Every output is forced low while rst is held, independent of the state register.
    assign need_port  = rst && (state == READ || state == WRITE);
    assign ctrl_owns  = need_port && (!bus.lookup_req || guard_fire);
    assign lookup_win = rst && bus.lookup_req && !ctrl_owns;

    assign bus.train_ready  = rst && (state == IDLE);
    assign bus.busy         = rst && (state != IDLE);
    assign bus.lookup_grant = lookup_win;
    assign bus.lookup_stall = bus.lookup_req && ctrl_owns;
    assign bus.ram_en       = ctrl_owns || lookup_win;
    assign bus.ram_we       = ctrl_owns && (state == WRITE);
    assign bus.ram_addr     = ctrl_owns ? index_q : (lookup_win ? bus.lookup_addr : '0);
    assign bus.ram_wdata    = (ctrl_owns && state == WRITE) ? row_q : '0;

    assign mispredict = (!sum_q[SUM_W-1]) != taken_q;
    assign sum_abs    = sum_q[SUM_W-1] ? ((~sum_q) + SUM_W'(1)) : sum_q;
    assign low_conf   = (sum_abs <= SUM_W'(THETA));

    // Bit 0 stands in for the bias input so that w0 moves toward the outcome itself.
    assign hist_ext = {ghr_q, 1'b1};
    assign up       = (hist_ext[k_q] == taken_q);
    assign w_cur    = row_q[k_q*WEIGHT_W +: WEIGHT_W];

    always_comb begin
        w_next = w_cur;
        if (up && w_cur != W_MAX) begin
            w_next = w_cur + WEIGHT_W'(1);
        end else if (!up && w_cur != W_MIN) begin
            w_next = w_cur - WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            index_q <= '0;
            ghr_q   <= '0;
            sum_q   <= '0;
            taken_q <= 1'b0;
            row_q   <= '0;
            k_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.train_valid) begin
                        index_q <= bus.train_index;
                        ghr_q   <= bus.train_ghr;
                        sum_q   <= bus.train_sum;
                        taken_q <= bus.train_taken;
                        state   <= DECIDE;
                    end
                end
                DECIDE:  state <= (mispredict || low_conf) ? READ : IDLE;
                READ:    if (ctrl_owns) state <= CAPTURE;
                CAPTURE: begin
                    row_q <= bus.ram_rdata;
                    k_q   <= '0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    row_q[k_q*WEIGHT_W +: WEIGHT_W] <= w_next;
                    if (k_q == K_W'(HIST_LEN)) begin
                        state <= WRITE;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                WRITE:   if (ctrl_owns) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
